// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FWFT fifo write port among N requesters, locking a grant for up to MAX_BURST beats.
// Define FIFO_ARB_STATS_EN to build saturating per-requester accepted-beat counters on grant_count.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [WIDTH-1:0]     fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [N*CNT_W-1:0]   grant_count
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_nxt;
  logic [PTR_W-1:0]  owner, owner_nxt;
  logic [BC_W-1:0]   beat_cnt, beat_nxt;
  logic [PTR_W-1:0]  sel;
  logic [PTR_W-1:0]  cur;
  logic              any_valid;
  logic              active;
  logic              cur_valid;
  logic              cur_last;
  logic              xfer;
  logic              cap_hit;

  function automatic logic [PTR_W-1:0] ptr_wrap(input logic [PTR_W-1:0] k);
    if (int'(k) == N - 1) return '0;
    return k + 1'b1;
  endfunction

  // Rotating priority scan starting at rr_ptr
  always_comb begin
    int idx;
    sel       = '0;
    any_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      idx = (int'(rr_ptr) + j) % N;
      if (!any_valid && req_valid[idx]) begin
        sel       = PTR_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  // Reset gates the grant combinationally so nothing is written while arst_n is low
  assign cur    = (state == IDLE) ? sel : owner;
  assign active = arst_n && ((state == BURST) || any_valid);

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    fifo_din  = '0;
    gnt       = '0;
    req_ready = '0;
    for (int j = 0; j < N; j++) begin
      if (cur == PTR_W'(j)) begin
        cur_valid = req_valid[j];
        cur_last  = req_last[j];
        if (active) begin
          fifo_din     = req_data[j*WIDTH +: WIDTH];
          gnt[j]       = 1'b1;
          req_ready[j] = !fifo_full;
        end
      end
    end
  end

  assign xfer       = active && cur_valid && !fifo_full;
  assign fifo_wr_en = xfer;
  assign busy       = (state == BURST);
  assign cap_hit    = ((beat_cnt + 1'b1) == BC_W'(MAX_BURST));

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          owner_nxt = sel;
          if (xfer && (cur_last || MAX_BURST == 1)) begin
            rr_nxt   = ptr_wrap(sel);
            beat_nxt = '0;
          end else begin
            state_nxt = BURST;
            beat_nxt  = xfer ? BC_W'(1) : '0;
          end
        end
      end
      BURST: begin
        // An owner that drops valid forfeits the rest of its burst
        if (!cur_valid || (xfer && (cur_last || cap_hit))) begin
          state_nxt = IDLE;
          rr_nxt    = ptr_wrap(owner);
          beat_nxt  = '0;
        end else if (xfer) begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] stat_cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_stats
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        stat_cnt[g] <= '0;
      end else if (xfer && gnt[g]) begin
        stat_cnt[g] <= sat_inc(stat_cnt[g]);
      end
    end
    assign grant_count[g*CNT_W +: CNT_W] = stat_cnt[g];
  end
`else
  assign grant_count = '0;
`endif

endmodule
